mem_stage: RTL and testbench

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. Consumes ALU results and store data from execute, performs loads and stores over a request/grant/response data-memory port, and aligns and sign-extends load data. Writes the MEM/WB register and drives the EX/MEM forwarding taps back to execute. Stalls the pipeline while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues loads/stores over a req/gnt/rvalid port, aligns load data and
// stalls upstream while a transaction is outstanding.

package mem_stage_pkg;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]           alu_result;
        logic [XLEN-1:0]           rs2_data_str;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        ctrl_t                     ctrl;
        logic                      valid_ex_mem;
    } ex_mem_reg_t;

    typedef struct packed {
        logic [XLEN-1:0]           result;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      reg_write;
        logic                      valid_mem_wb;
    } mem_wb_reg_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  ex_mem_reg_t               ex_mem_in,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [XLEN-1:0]           dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [XLEN-1:0]           dmem_rdata,
    output mem_wb_reg_t               mem_wb_out,
    output logic [XLEN-1:0]           mem_alu_result,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                      mem_reg_write,
    output logic                      mem_stall,
    output logic                      misalign_exc,
    output logic                      bus_err
);

    localparam int unsigned     CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_wb_reg_t       wb_q, wb_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              mem_op, is_load, is_store, aligned;
    logic              advance, complete, timeout;
    logic [1:0]        addr_lo;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_data;

    assign addr_lo  = ex_mem_in.alu_result[1:0];
    assign mem_op   = ex_mem_in.valid_ex_mem &
                      (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
    assign is_store = mem_op & ex_mem_in.ctrl.mem_write;
    assign is_load  = mem_op & ~ex_mem_in.ctrl.mem_write;

    // Alignment check by access size (funct3[1:0]: 00 byte, 01 half, else word)
    always_comb begin
        case (ex_mem_in.ctrl.mem_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_lo[0];
            default: aligned = (addr_lo == 2'b00);
        endcase
    end

    // Handshake progress for the current state; a gnt in REQ counts as
    // progress even for loads so the timeout never drops an accepted request
    always_comb begin
        advance  = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: complete = is_store & aligned & dmem_gnt;
            REQ: begin
                advance  = dmem_gnt;
                complete = is_store & dmem_gnt;
            end
            RESP: begin
                advance  = dmem_rvalid;
                complete = dmem_rvalid;
            end
            default: ;
        endcase
    end

    assign timeout   = (MAX_WAIT != 0) && (state_q != IDLE) &&
                       (cnt_q == MAX_CNT) && !advance;
    assign mem_stall = mem_op & aligned & ~complete & ~timeout;

    // FSM state and wait-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_q       <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_q       <= wb_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_op && aligned) begin
                    if (dmem_gnt) state_d = is_load ? RESP : IDLE;
                    else          state_d = REQ;
                end
            end
            REQ: begin
                if (timeout)       state_d = IDLE;
                else if (dmem_gnt) state_d = is_load ? RESP : IDLE;
            end
            RESP: begin
                if (dmem_rvalid || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait counter: runs across REQ and RESP, cleared in and on return to IDLE
    always_comb begin
        if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
        else                                    cnt_d = cnt_q + CNT_W'(1);
    end

    // FSM outputs: request valid
    always_comb begin
        dmem_req = 1'b0;
        case (state_q)
            IDLE:    dmem_req = mem_op & aligned;
            REQ:     dmem_req = ~timeout;
            default: dmem_req = 1'b0;
        endcase
    end

    // Store data lane replication and byte enables
    always_comb begin
        case (ex_mem_in.ctrl.mem_funct3[1:0])
            2'b00: begin
                dmem_wdata = {4{ex_mem_in.rs2_data_str[7:0]}};
                dmem_be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                dmem_wdata = {2{ex_mem_in.rs2_data_str[15:0]}};
                dmem_be    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                dmem_wdata = ex_mem_in.rs2_data_str;
                dmem_be    = 4'b1111;
            end
        endcase
        if (!is_store) dmem_be = '0;
    end

    assign dmem_we   = is_store;
    assign dmem_addr = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};

    // Load lane selection and sign/zero extension
    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ex_mem_in.ctrl.mem_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // MEM/WB next value: bubble on stall, misaligned drop or abort
    always_comb begin
        wb_d       = '0;
        misalign_d = mem_op & ~aligned & (state_q == IDLE);
        bus_err_d  = timeout;
        if (!mem_stall && !misalign_d && !timeout) begin
            wb_d.result       = is_load ? load_data : ex_mem_in.alu_result;
            wb_d.rd_addr      = ex_mem_in.rd_addr;
            wb_d.reg_write    = ex_mem_in.ctrl.reg_write & ex_mem_in.valid_ex_mem;
            wb_d.valid_mem_wb = ex_mem_in.valid_ex_mem;
        end
    end

    assign mem_wb_out     = wb_q;
    assign misalign_exc   = misalign_q;
    assign bus_err        = bus_err_q;
    assign mem_alu_result = ex_mem_in.alu_result;
    assign mem_rd_addr    = ex_mem_in.rd_addr;
    assign mem_reg_write  = ex_mem_in.valid_ex_mem & ex_mem_in.ctrl.reg_write &
                            ~ex_mem_in.ctrl.mem_read;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage (MAX_WAIT=4).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                      clk;
    logic                      reset;
    ex_mem_reg_t               ex_mem_in;
    logic                      dmem_req, dmem_we;
    logic [XLEN-1:0]           dmem_addr, dmem_wdata;
    logic [3:0]                dmem_be;
    logic                      dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0]           dmem_rdata;
    mem_wb_reg_t               mem_wb_out;
    logic [XLEN-1:0]           mem_alu_result;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
    logic                      mem_reg_write, mem_stall, misalign_exc, bus_err;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .ex_mem_in(ex_mem_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_wb_out(mem_wb_out), .mem_alu_result(mem_alu_result),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .mem_stall(mem_stall), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ex_mem_reg_t mk(input logic [31:0] alu, input logic [31:0] rs2,
                                       input logic [4:0] rd, input logic rd_en,
                                       input logic wr_en, input logic [2:0] f3,
                                       input logic rw);
        ex_mem_reg_t e;
        e.alu_result           = alu;
        e.rs2_data_str         = rs2;
        e.rd_addr              = rd;
        e.ctrl.mem_read        = rd_en;
        e.ctrl.mem_write       = wr_en;
        e.ctrl.mem_funct3      = f3;
        e.ctrl.reg_write       = rw;
        e.valid_ex_mem         = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.result = r; e.rd = rd; e.rw = rw;
        sb_q.push_back(e);
    endtask

    // Zero-wait store: expected bus signals checked in the issue cycle
    task automatic store_fast(input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [2:0] f3, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_be);
        ex_mem_in = mk(addr, rs2, 5'd0, 1'b0, 1'b1, f3, 1'b0);
        dmem_gnt  = 1'b1;
        push(addr, 5'd0, 1'b0);
        #1;
        chk("st_req",   {31'd0, dmem_req}, 32'd1);
        chk("st_we",    {31'd0, dmem_we}, 32'd1);
        chk("st_addr",  dmem_addr, {addr[31:2], 2'b00});
        chk("st_wdata", dmem_wdata, exp_wdata);
        chk("st_be",    {28'd0, dmem_be}, {28'd0, exp_be});
        chk("st_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        ex_mem_in = '0;
        dmem_gnt  = 1'b0;
    endtask

    // Load granted immediately, data one cycle later
    task automatic load_fast(input logic [31:0] addr, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] rdata,
                             input logic [31:0] exp);
        ex_mem_in = mk(addr, 32'd0, rd, 1'b1, 1'b0, f3, 1'b1);
        dmem_gnt  = 1'b1;
        #1;
        chk("ld_c0_stall", {31'd0, mem_stall}, 32'd1);
        chk("ld_c0_be",    {28'd0, dmem_be}, 32'd0);
        chk("ld_c0_we",    {31'd0, dmem_we}, 32'd0);
        chk("ld_fwd_rw",   {31'd0, mem_reg_write}, 32'd0);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        push(exp, rd, 1'b1);
        #1;
        chk("ld_c1_stall", {31'd0, mem_stall}, 32'd0);
        chk("ld_c1_req",   {31'd0, dmem_req}, 32'd0);
        tick();
        ex_mem_in   = '0;
        dmem_rvalid = 1'b0;
    endtask

    // Monitor: every valid MEM/WB entry must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_wb_out.valid_mem_wb) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL wb_unexpected: got result 0x%08h rd %0d with no expected entry",
                         mem_wb_out.result, mem_wb_out.rd_addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_result", mem_wb_out.result, e.result);
                chk("wb_rd",     {27'd0, mem_wb_out.rd_addr}, {27'd0, e.rd});
                chk("wb_rw",     {31'd0, mem_wb_out.reg_write}, {31'd0, e.rw});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        ex_mem_in   = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);
        chk("rst_wb_result", mem_wb_out.result, 32'd0);
        chk("rst_req",      {31'd0, dmem_req}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
        chk("rst_bus_err",  {31'd0, bus_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Non-memory op passes through in one cycle
        ex_mem_in = mk(32'h1234, 32'd0, 5'd5, 1'b0, 1'b0, 3'b000, 1'b1);
        push(32'h1234, 5'd5, 1'b1);
        #1;
        chk("add_stall",  {31'd0, mem_stall}, 32'd0);
        chk("add_req",    {31'd0, dmem_req}, 32'd0);
        chk("add_fwd_rw", {31'd0, mem_reg_write}, 32'd1);
        chk("add_fwd_res", mem_alu_result, 32'h1234);
        chk("add_fwd_rd", {27'd0, mem_rd_addr}, 32'd5);
        tick();
        ex_mem_in = '0;

        // Stores with zero-wait grant
        store_fast(32'h103, 32'hAABBCCDD, 3'b000, 32'hDDDDDDDD, 4'b1000);
        store_fast(32'h102, 32'h1234ABCD, 3'b001, 32'hABCDABCD, 4'b1100);
        store_fast(32'h104, 32'hCAFEF00D, 3'b010, 32'hCAFEF00D, 4'b1111);

        // LB with gnt delayed two cycles and data one cycle after gnt
        ex_mem_in = mk(32'h102, 32'd0, 5'd7, 1'b1, 1'b0, 3'b000, 1'b1);
        #1;
        chk("lb_c0_stall", {31'd0, mem_stall}, 32'd1);
        chk("lb_c0_req",   {31'd0, dmem_req}, 32'd1);
        tick();
        chk("lb_c1_stall", {31'd0, mem_stall}, 32'd1);
        chk("lb_c1_req",   {31'd0, dmem_req}, 32'd1);
        chk("lb_c1_addr",  dmem_addr, 32'h100);
        tick();
        dmem_gnt = 1'b1;
        #1;
        chk("lb_c2_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h00800000;
        push(32'hFFFFFF80, 5'd7, 1'b1);
        #1;
        chk("lb_c3_stall", {31'd0, mem_stall}, 32'd0);
        chk("lb_c3_req",   {31'd0, dmem_req}, 32'd0);
        tick();
        ex_mem_in   = '0;
        dmem_rvalid = 1'b0;

        load_fast(32'h102, 3'b100, 5'd8,  32'h00800000, 32'h00000080);
        load_fast(32'h102, 3'b001, 5'd11, 32'h80000000, 32'hFFFF8000);
        load_fast(32'h102, 3'b101, 5'd12, 32'h80000000, 32'h00008000);
        load_fast(32'h100, 3'b010, 5'd13, 32'hDEADBEEF, 32'hDEADBEEF);
        load_fast(32'h101, 3'b100, 5'd14, 32'h0000F100, 32'h000000F1);

        // Misaligned LW and SH: no request, exception pulse, bubble
        ex_mem_in = mk(32'h202, 32'd0, 5'd6, 1'b1, 1'b0, 3'b010, 1'b1);
        #1;
        chk("mis_lw_req",   {31'd0, dmem_req}, 32'd0);
        chk("mis_lw_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        ex_mem_in = '0;
        chk("mis_lw_exc",   {31'd0, misalign_exc}, 32'd1);
        chk("mis_lw_wbv",   {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);
        tick();
        chk("mis_exc_clr",  {31'd0, misalign_exc}, 32'd0);
        ex_mem_in = mk(32'h201, 32'h5555, 5'd0, 1'b0, 1'b1, 3'b001, 1'b0);
        #1;
        chk("mis_sh_req",   {31'd0, dmem_req}, 32'd0);
        tick();
        ex_mem_in = '0;
        chk("mis_sh_exc",   {31'd0, misalign_exc}, 32'd1);
        chk("mis_sh_wbv",   {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);
        tick();

        // Load granted, rvalid never arrives: abort after 4 wait cycles
        ex_mem_in = mk(32'h300, 32'd0, 5'd9, 1'b1, 1'b0, 3'b010, 1'b1);
        dmem_gnt  = 1'b1;
        #1;
        chk("to_c0_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_stall", {31'd0, mem_stall}, 32'd1);
            tick();
        end
        chk("to_abort_stall", {31'd0, mem_stall}, 32'd0);
        chk("to_abort_req",   {31'd0, dmem_req}, 32'd0);
        tick();
        ex_mem_in = '0;
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_wbv",     {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);
        tick();
        chk("to_bus_err_clr", {31'd0, bus_err}, 32'd0);

        // Reset while waiting in RESP, then a stray rvalid
        ex_mem_in = mk(32'h400, 32'd0, 5'd10, 1'b1, 1'b0, 3'b010, 1'b1);
        dmem_gnt  = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("rr_resp_stall", {31'd0, mem_stall}, 32'd1);
        reset     = 1'b1;
        ex_mem_in = '0;
        tick();
        chk("rr_req",    {31'd0, dmem_req}, 32'd0);
        chk("rr_wbv",    {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);
        chk("rr_wbres",  mem_wb_out.result, 32'd0);
        reset = 1'b0;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        #1;
        chk("rr_stray_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        chk("rr_stray_wbv", {31'd0, mem_wb_out.valid_mem_wb}, 32'd0);

        // Back in IDLE: a plain op flows normally
        ex_mem_in = mk(32'h55, 32'd0, 5'd3, 1'b0, 1'b0, 3'b000, 1'b1);
        push(32'h55, 5'd3, 1'b1);
        #1;
        chk("post_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        ex_mem_in = '0;
        tick();
        tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
